// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with optional hold watchdog (ARB_TIMEOUT_EN)
module rr_arbiter4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic       r_busy;
  logic [3:0] w_elig;
  logic [3:0] w_owner;
  logic [3:0] w_elig_oth;
  logic [1:0] w_pick_all;
  logic [1:0] w_pick_oth;

  // First eligible index in the order ptr+1, ptr+2, ptr+3, ptr.
  function automatic logic [1:0] f_pick(input logic [3:0] elig, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] cand;
    idx = ptr;
    for (int i = 4; i >= 1; i--) begin
      cand = ptr + 2'(i);
      if (elig[cand]) idx = cand;
    end
    return idx;
  endfunction

  function automatic logic [3:0] f_dec(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MAX_HOLD - 1);

  logic [3:0]       r_mask, w_mask_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;

  assign w_elig  = req & ~r_mask;
  assign timeout = r_timeout;
`else
  assign w_elig  = req;
  assign timeout = 1'b0;
`endif

  assign w_owner    = f_dec(r_ptr);
  assign w_elig_oth = w_elig & ~w_owner;
  assign w_pick_all = f_pick(w_elig, r_ptr);
  assign w_pick_oth = f_pick(w_elig_oth, r_ptr);

  // Next-state decision: grant from idle, hold, hand over on release, or revoke on watchdog expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
`ifdef ARB_TIMEOUT_EN
    w_mask_nxt    = r_mask & req;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
`endif
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_gnt_nxt   = 4'b0000;
    end else if (r_state == S_IDLE) begin
      if (|w_elig) begin
        w_state_nxt = S_GRANT;
        w_ptr_nxt   = w_pick_all;
        w_gnt_nxt   = f_dec(w_pick_all);
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt   = '0;
`endif
      end
    end else if (!req[r_ptr]) begin
      if (|w_elig_oth) begin
        w_ptr_nxt = w_pick_oth;
        w_gnt_nxt = f_dec(w_pick_oth);
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt = '0;
`endif
      end else begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
`ifdef ARB_TIMEOUT_EN
    end else if (r_cnt == LP_LAST) begin
      // Owner held too long: mask it until it drops req, then pass on or go idle.
      w_timeout_nxt = 1'b1;
      w_mask_nxt    = (r_mask & req) | w_owner;
      w_cnt_nxt     = '0;
      if (|w_elig_oth) begin
        w_ptr_nxt = w_pick_oth;
        w_gnt_nxt = f_dec(w_pick_oth);
      end else begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
    end
  end

  // State and output registers; reset parks ptr at 3 so the first search starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= 4'b0000;
      r_ptr   <= 2'b11;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= (w_state_nxt == S_GRANT);
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog state: hold counter, per-client mask and the revoke pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask    <= 4'b0000;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_mask    <= w_mask_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end
`endif

  assign gnt     = r_gnt;
  assign gnt_idx = r_ptr;
  assign busy    = r_busy;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - table-driven bench for rr_arbiter4
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int n_vec;
  int n_bad;

  typedef struct packed {
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
  } vec_t;

  vec_t vecs [27];

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ei,
                       input logic eb, input logic et);
    n_vec++;
    if (gnt !== eg || gnt_idx !== ei || busy !== eb || timeout !== et) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b idx=%0d busy=%b timeout=%b, want gnt=%b idx=%0d busy=%b timeout=%b",
               name, gnt, gnt_idx, busy, timeout, eg, ei, eb, et);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    //            en    req      gnt      idx   busy
    vecs[0]  = '{1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1};
    vecs[1]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[2]  = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};
    vecs[3]  = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1};
    vecs[4]  = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1};
    vecs[5]  = '{1'b1, 4'b0111, 4'b0001, 2'd0, 1'b1};
    vecs[6]  = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1};
    vecs[7]  = '{1'b1, 4'b1110, 4'b0010, 2'd1, 1'b1};
    vecs[8]  = '{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1};
    vecs[9]  = '{1'b1, 4'b1101, 4'b0100, 2'd2, 1'b1};
    vecs[10] = '{1'b1, 4'b1011, 4'b1000, 2'd3, 1'b1};
    vecs[11] = '{1'b1, 4'b0111, 4'b0001, 2'd0, 1'b1};
    vecs[12] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[13] = '{1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0};
    vecs[14] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[15] = '{1'b0, 4'b0100, 4'b0000, 2'd2, 1'b0};
    vecs[16] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[17] = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};
    vecs[18] = '{1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0};
    vecs[19] = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};
    vecs[20] = '{1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0};
    vecs[21] = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[22] = '{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1};
    vecs[23] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[24] = '{1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[25] = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[26] = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1};

    rst = 1'b1;
    en  = 1'b0;
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 4'b0000, 2'd3, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      step(vecs[i].en, vecs[i].req);
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].busy, 1'b0);
    end

    // Asynchronous reset while client 3 owns the grant.
    #1 rst = 1'b1;
    #1 check("async_rst", 4'b0000, 2'd3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 4'b1000);
    check("post_rst", 4'b1000, 2'd3, 1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 4'b0011);
    check("to_hold1", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      step(1'b1, 4'b0011);
      check($sformatf("to_hold%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step(1'b1, 4'b0011);
    check("to_revoke", 4'b0010, 2'd1, 1'b1, 1'b1);
    step(1'b1, 4'b0011);
    check("to_pulse_end", 4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b1, 4'b0001);
    check("to_masked_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    step(1'b1, 4'b0001);
    check("to_masked_hold", 4'b0000, 2'd1, 1'b0, 1'b0);
    step(1'b1, 4'b0000);
    check("to_unmask", 4'b0000, 2'd1, 1'b0, 1'b0);
    step(1'b1, 4'b0001);
    check("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
